acm_scrub_sequencer: RTL
========================

# acm_scrub_sequencer

Parametrised Automatic Correction Mechanism (ACM) address sequencer for the register-file scrub path. It sits beside the ID stage. Each cycle it hands consecutive scrub read addresses to any number of register-file read ports that the instruction entering OP does not need. It also serves an out-of-order re-check of one specific register after a detected mismatch, and reports sweep completion.

## Interface
- NPORTS, 2, number of register-file read ports to fill; legal range 1 to LAST-FIRST+1
- AW, 5, register address width
- FIRST, 1, lowest scanned address; register 0 is never scanned by default
- LAST, 31, highest scanned address; FIRST <= LAST < 2**AW
- s_clk_i  in  1  clock
- s_reset_i  in  1  reset, synchronous, active-high
- s_mode_i  in  2  ACM mode: 00 off, 01 linear, 10 linear+recheck, 11 freeze
- s_flush_i  in  1  pipeline flush; no read ports are consumed this cycle
- s_free_i  in  NPORTS  bit p set: read port p is unused by the instruction entering OP
- s_recheck_req_i  in  1  request a re-read of s_recheck_add_i
- s_recheck_add_i  in  AW  address to re-check; must lie in FIRST..LAST
- s_add_o  out  NPORTS*AW  scrub address for port p in bits [p*AW +: AW]
- s_valid_o  out  NPORTS  bit p set: s_add_o slot p is a scrub address and the port is substituted
- s_recheck_busy_o  out  1  re-check pending, not yet served
- s_sweep_done_o  out  1  one-cycle pulse after the pointer wraps LAST to FIRST
- s_sweep_cnt_o  out  16  completed sweeps, saturating

## Operation
- State: r_ptr (AW bits), r_pend (1 bit), r_pend_add (AW bits), r_sweep_done, r_sweep_cnt.
- Ports are ranked by ascending index among set s_free_i bits. The j-th free port (j = 0..k-1, k = popcount) gets wrap(r_ptr + j). Its s_valid_o bit is set. Non-free ports have s_valid_o = 0 and s_add_o = 0.
- wrap(x): computed in AW+1 bits; if x > LAST then x - (LAST-FIRST+1). A single subtraction suffices because NPORTS <= range.
- Linear (01): r_ptr <= wrap(r_ptr + k). If k = 0 and s_flush_i = 1, then r_ptr <= wrap(r_ptr + 1). Flush with k > 0 advances by k only.
- Linear+recheck (10): if r_pend and k >= 1, the lowest free port gets r_pend_add. The remaining k-1 free ports take the sequential addresses from r_ptr. r_ptr advances by k-1, and r_pend clears.
- Recheck capture (mode 10 only): s_recheck_req_i sets r_pend and r_pend_add when r_pend is 0, or in the cycle r_pend is being served. Requests arriving while pending and not served are dropped.
- Freeze (11): every free port gets r_ptr. r_ptr holds, no recheck service, r_pend holds.
- Off (00): s_valid_o = 0, r_ptr holds, r_pend clears, requests are ignored.
- Sweep: any r_ptr update whose unwrapped sum exceeds LAST sets r_sweep_done for the next cycle and increments r_sweep_cnt, saturating at 16'hFFFF.
- Mode changes take effect in the same cycle; state is not reset.

## Timing
- s_add_o and s_valid_o are combinational from registered state, s_mode_i and s_free_i, with zero latency in the cycle ID writes the IDOP registers. There is no combinational path from s_recheck_* to outputs.
- A recheck request is served at the earliest on the next cycle with k >= 1. s_recheck_busy_o = r_pend, registered.
- s_sweep_done_o is registered: it rises the cycle after the wrapping update and lasts 1 cycle.
- Reset values: r_ptr = FIRST, r_pend = 0, r_pend_add = 0, s_sweep_done_o = 0, s_sweep_cnt_o = 0. s_valid_o = 0 during reset, regardless of mode.
- Reset asserted mid-recheck discards the pending request at the next edge.

## Structure
- Package p_hardisc holds the mode constants ACM_OFF = 2'b00, ACM_LIN = 2'b01, ACM_LINCHK = 2'b10, ACM_FRZ = 2'b11.
- Sub-module acm_wrap_add (parameters AW, FIRST, LAST): computes wrap(a + b) and a carry-out flag that signals a sweep. It is instantiated NPORTS times for the port addresses and once for the pointer update.
- Single always_ff for state; port ranking via an always_comb prefix-count loop.

## Test plan
- Reset, mode 01, NPORTS=2, s_free_i=2'b11 for 3 cycles -> ports get {1,2}, {3,4}, {5,6}; r_ptr = 7.
- Pointer at 30, s_free_i=2'b11 -> ports get {30,31}, r_ptr = 1; s_sweep_done_o = 1 next cycle only; s_sweep_cnt_o = 1.
- Mode 01, s_free_i=2'b10, r_ptr = 4 -> port 1 gets 4 with s_valid_o=2'b10, r_ptr = 5. Then s_free_i=0 with s_flush_i=1 -> r_ptr = 6.
- Mode 10, recheck of 17 at r_ptr = 9, next cycle s_free_i=2'b11 -> port 0 gets 17, port 1 gets 9, r_ptr = 10, busy drops. A second request during pending is dropped.
- Mode 11 for 4 cycles with s_free_i=2'b11 -> both ports show r_ptr and r_ptr is unchanged. Then mode 00 -> s_valid_o = 0 and a pending recheck is cleared.
- Reset asserted with r_pend = 1 and r_ptr = 20 -> the next cycle shows r_ptr = 1, busy = 0 and the sweep count = 0.

Source files
------------

// File: rtl/acm_scrub_sequencer_pkg.sv
// Shared definitions for the register-file scrub (ACM) address sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package p_hardisc;

    // ACM operating modes, encoded exactly as driven on s_mode_i.
    typedef enum logic [1:0] {
        ACM_OFF    = 2'b00,
        ACM_LIN    = 2'b01,
        ACM_LINCHK = 2'b10,
        ACM_FRZ    = 2'b11
    } acm_mode_e;

endpackage

// File: rtl/acm_scrub_sequencer_wrap_add.sv
// Modular adder over the scanned window FIRST..LAST: sum_o = wrap(a_i + b_i).
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
//
// Ports:
//   a_i     in  AW    base address, assumed in FIRST..LAST
//   b_i     in  AW+1  offset, at most LAST-FIRST+1
//   sum_o   out AW    wrapped address, back inside FIRST..LAST
//   carry_o out 1     raw sum passed LAST (the window wrapped)
module acm_wrap_add #(
    parameter int AW    = 5,
    parameter int FIRST = 1,
    parameter int LAST  = 31
) (
    input  logic [AW-1:0] a_i,
    input  logic [AW:0]   b_i,
    output logic [AW-1:0] sum_o,
    output logic          carry_o
);

    localparam logic [AW:0] LAST_W  = (AW+1)'(LAST);
    localparam logic [AW:0] RANGE_W = (AW+1)'(LAST - FIRST + 1);

    logic [AW:0] raw;

    // One subtraction is enough: a_i <= LAST and b_i <= range keeps the
    // raw sum below LAST + range.
    always_comb begin
        raw     = {1'b0, a_i} + b_i;
        carry_o = (raw > LAST_W);
        sum_o   = carry_o ? AW'(raw - RANGE_W) : AW'(raw);
    end

endmodule

// File: rtl/acm_scrub_sequencer.sv
// Hands consecutive scrub read addresses to unused register-file read ports, with one-shot re-check service.
// Latency: s_add_o/s_valid_o combinational from state, mode and s_free_i; status outputs registered.
// Backpressure: none; only ports flagged free are consumed, the pointer advances by the number consumed.
//
// Ports:
//   s_clk_i, s_reset_i              clock, synchronous active-high reset
//   s_mode_i                        00 off, 01 linear, 10 linear+recheck, 11 freeze
//   s_flush_i                       no ports consumed; nudges the pointer when nothing is free
//   s_free_i[NPORTS]                read ports the instruction entering OP leaves unused
//   s_recheck_req_i/s_recheck_add_i request a re-read of one register (mode 10)
//   s_add_o[NPORTS*AW]              scrub address per port, slot p at [p*AW +: AW]
//   s_valid_o[NPORTS]               slot p carries a scrub address
//   s_recheck_busy_o                a re-check is pending
//   s_sweep_done_o, s_sweep_cnt_o   wrap pulse and saturating sweep count
module acm_scrub_sequencer
    import p_hardisc::*;
#(
    parameter int NPORTS = 2,
    parameter int AW     = 5,
    parameter int FIRST  = 1,
    parameter int LAST   = 31
) (
    input  logic                 s_clk_i,
    input  logic                 s_reset_i,
    input  logic [1:0]           s_mode_i,
    input  logic                 s_flush_i,
    input  logic [NPORTS-1:0]    s_free_i,
    input  logic                 s_recheck_req_i,
    input  logic [AW-1:0]        s_recheck_add_i,
    output logic [NPORTS*AW-1:0] s_add_o,
    output logic [NPORTS-1:0]    s_valid_o,
    output logic                 s_recheck_busy_o,
    output logic                 s_sweep_done_o,
    output logic [15:0]          s_sweep_cnt_o
);

    acm_mode_e mode;
    assign mode = acm_mode_e'(s_mode_i);

    logic [AW-1:0] ptr_q, ptr_d;
    logic          pend_q, pend_d;
    logic [AW-1:0] pend_add_q, pend_add_d;
    logic          sweep_done_q, sweep_done_d;
    logic [15:0]   sweep_cnt_q, sweep_cnt_d;

    // Rank of each port among the free ones, and the free-port count k.
    logic [NPORTS-1:0][AW:0] port_rank;
    logic [AW:0]             k;

    always_comb begin
        logic [AW:0] rank;
        rank      = '0;
        port_rank = '0;
        for (int p = 0; p < NPORTS; p++) begin
            port_rank[p] = rank;
            if (s_free_i[p]) begin
                rank = rank + (AW+1)'(1);
            end
        end
        k = rank;
    end

    // The pending re-check takes the lowest free port.
    logic serve;
    assign serve = (mode == ACM_LINCHK) && pend_q && (k != '0);

    // Per-port offset from the pointer. When serving, the sequential
    // addresses start at the second free port, so the rank shifts down by one.
    logic [NPORTS-1:0][AW:0]   port_ofs;
    logic [NPORTS-1:0][AW-1:0] port_seq;
    logic [NPORTS-1:0]         port_carry_unused;

    always_comb begin
        port_ofs = '0;
        for (int p = 0; p < NPORTS; p++) begin
            if (mode == ACM_FRZ) begin
                port_ofs[p] = '0;
            end else if (serve) begin
                port_ofs[p] = (port_rank[p] == '0) ? '0 : port_rank[p] - (AW+1)'(1);
            end else begin
                port_ofs[p] = port_rank[p];
            end
        end
    end

    for (genvar gp = 0; gp < NPORTS; gp++) begin : g_port_add
        acm_wrap_add #(
            .AW    (AW),
            .FIRST (FIRST),
            .LAST  (LAST)
        ) u_port_add (
            .a_i     (ptr_q),
            .b_i     (port_ofs[gp]),
            .sum_o   (port_seq[gp]),
            .carry_o (port_carry_unused[gp])
        );
    end

    always_comb begin
        s_add_o   = '0;
        s_valid_o = '0;
        for (int p = 0; p < NPORTS; p++) begin
            if (s_free_i[p] && !s_reset_i && (mode != ACM_OFF)) begin
                s_valid_o[p] = 1'b1;
                if (serve && (port_rank[p] == '0)) begin
                    s_add_o[p*AW +: AW] = pend_add_q;
                end else begin
                    s_add_o[p*AW +: AW] = port_seq[p];
                end
            end
        end
    end

    // Pointer advance. Off and freeze hold; a flush with nothing free still
    // moves the pointer by one so the sweep keeps making progress.
    logic [AW:0]   adv;
    logic [AW-1:0] ptr_nxt;
    logic          ptr_carry;

    always_comb begin
        adv = '0;
        if ((mode == ACM_LIN) || (mode == ACM_LINCHK)) begin
            adv = serve ? k - (AW+1)'(1) : k;
            if ((k == '0) && s_flush_i) begin
                adv = (AW+1)'(1);
            end
        end
    end

    acm_wrap_add #(
        .AW    (AW),
        .FIRST (FIRST),
        .LAST  (LAST)
    ) u_ptr_add (
        .a_i     (ptr_q),
        .b_i     (adv),
        .sum_o   (ptr_nxt),
        .carry_o (ptr_carry)
    );

    always_comb begin
        ptr_d        = ptr_nxt;
        sweep_done_d = ptr_carry;
        sweep_cnt_d  = sweep_cnt_q;
        if (ptr_carry && (sweep_cnt_q != 16'hFFFF)) begin
            sweep_cnt_d = sweep_cnt_q + 16'd1;
        end

        pend_d     = pend_q;
        pend_add_d = pend_add_q;
        case (mode)
            ACM_OFF: begin
                pend_d = 1'b0;
            end
            ACM_LINCHK: begin
                if (serve) begin
                    pend_d = 1'b0;
                end
                // A new request is taken when nothing is pending or the
                // pending one leaves this cycle; otherwise it is dropped.
                if ((serve || !pend_q) && s_recheck_req_i) begin
                    pend_d     = 1'b1;
                    pend_add_d = s_recheck_add_i;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge s_clk_i) begin
        if (s_reset_i) begin
            ptr_q        <= AW'(FIRST);
            pend_q       <= 1'b0;
            pend_add_q   <= '0;
            sweep_done_q <= 1'b0;
            sweep_cnt_q  <= '0;
        end else begin
            ptr_q        <= ptr_d;
            pend_q       <= pend_d;
            pend_add_q   <= pend_add_d;
            sweep_done_q <= sweep_done_d;
            sweep_cnt_q  <= sweep_cnt_d;
        end
    end

    assign s_recheck_busy_o = pend_q;
    assign s_sweep_done_o   = sweep_done_q;
    assign s_sweep_cnt_o    = sweep_cnt_q;

endmodule
